register_bank_32x8: RTL and testbench

- Architectural general-purpose register storage (R0..R31) for the ATMega32A emulator core.
- Sits directly upstream of the 32-way read multiplexers; each register value is driven on its own output port so it can be wired straight into the multiplexer reg0..reg31 inputs.
- Provides:
  - one byte write port;
  - one register-pair (word) write port for MOVW/ADIW/SBIW results;
  - a pointer post-increment/pre-decrement unit for the X/Y/Z pairs (R27:R26, R29:R28, R31:R30).

---
 rtl/register_bank_32x8.sv | 169 ++++++++++++++++
 tb/tb_register_bank_32x8.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/register_bank_32x8.sv
// register_bank_32x8
// General-purpose register file R0..R31 for the ATMega32A emulator core.
// Three writers share the bank: a byte port, a register-pair (word) port and
// the X/Y/Z pointer post-increment / pre-decrement unit. Conflicts are
// resolved independently for every byte: byte write, then word write, then
// pointer update. Every register is exposed on its own flop-driven port so it
// can feed the 32-way read multiplexers directly.

module register_bank_32x8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_word_en,
  input  logic [3:0]           wr_word_addr,
  input  logic [2*WIDTH-1:0]   wr_word_data,
  input  logic [1:0]           ptr_sel,
  input  logic                 ptr_inc,
  input  logic                 ptr_dec,
  output logic [2*WIDTH-1:0]   ptr_addr,
  output logic [WIDTH-1:0]     reg0_out,
  output logic [WIDTH-1:0]     reg1_out,
  output logic [WIDTH-1:0]     reg2_out,
  output logic [WIDTH-1:0]     reg3_out,
  output logic [WIDTH-1:0]     reg4_out,
  output logic [WIDTH-1:0]     reg5_out,
  output logic [WIDTH-1:0]     reg6_out,
  output logic [WIDTH-1:0]     reg7_out,
  output logic [WIDTH-1:0]     reg8_out,
  output logic [WIDTH-1:0]     reg9_out,
  output logic [WIDTH-1:0]     reg10_out,
  output logic [WIDTH-1:0]     reg11_out,
  output logic [WIDTH-1:0]     reg12_out,
  output logic [WIDTH-1:0]     reg13_out,
  output logic [WIDTH-1:0]     reg14_out,
  output logic [WIDTH-1:0]     reg15_out,
  output logic [WIDTH-1:0]     reg16_out,
  output logic [WIDTH-1:0]     reg17_out,
  output logic [WIDTH-1:0]     reg18_out,
  output logic [WIDTH-1:0]     reg19_out,
  output logic [WIDTH-1:0]     reg20_out,
  output logic [WIDTH-1:0]     reg21_out,
  output logic [WIDTH-1:0]     reg22_out,
  output logic [WIDTH-1:0]     reg23_out,
  output logic [WIDTH-1:0]     reg24_out,
  output logic [WIDTH-1:0]     reg25_out,
  output logic [WIDTH-1:0]     reg26_out,
  output logic [WIDTH-1:0]     reg27_out,
  output logic [WIDTH-1:0]     reg28_out,
  output logic [WIDTH-1:0]     reg29_out,
  output logic [WIDTH-1:0]     reg30_out,
  output logic [WIDTH-1:0]     reg31_out
);

  localparam int PW = 2 * WIDTH;

  // Architectural register storage and the per-byte next value.
  logic [WIDTH-1:0] r_regs [32];
  logic [WIDTH-1:0] w_next [32];

  // Pointer decode: X, Y and Z are pairs 13, 14 and 15 (R27:R26, R29:R28,
  // R31:R30), i.e. pair index 12 + ptr_sel. For ptr_sel = 0 the index is
  // meaningless and every use below is gated by w_ptr_any.
  logic [3:0]    w_ptr_pair;
  logic [4:0]    w_ptr_lo_idx;
  logic [4:0]    w_ptr_hi_idx;
  logic          w_ptr_any;
  logic          w_ptr_upd;
  logic          w_ptr_pre_dec;
  logic [PW-1:0] w_ptr_val;
  logic [PW-1:0] w_ptr_plus;
  logic [PW-1:0] w_ptr_minus;
  logic [PW-1:0] w_ptr_new;

  assign w_ptr_pair    = 4'd12 + {2'b00, ptr_sel};
  assign w_ptr_lo_idx  = {w_ptr_pair, 1'b0};
  assign w_ptr_hi_idx  = {w_ptr_pair, 1'b1};
  assign w_ptr_any     = (ptr_sel != 2'd0);
  // inc and dec together is illegal and behaves as a plain indirect access.
  assign w_ptr_upd     = w_ptr_any & (ptr_inc ^ ptr_dec);
  assign w_ptr_pre_dec = w_ptr_any & ptr_dec & ~ptr_inc;

  assign w_ptr_val   = {r_regs[w_ptr_hi_idx], r_regs[w_ptr_lo_idx]};
  // Modulo 2^PW arithmetic: the carry/borrow crosses the byte boundary and
  // anything out of the top simply drops.
  assign w_ptr_plus  = w_ptr_val + PW'(1);
  assign w_ptr_minus = w_ptr_val - PW'(1);
  assign w_ptr_new   = ptr_inc ? w_ptr_plus : w_ptr_minus;

  // Memory address for this cycle's access: pre-decrement shows the new
  // value, post-increment and plain access show the current one.
  always_comb begin
    ptr_addr = '0;
    if (w_ptr_any) begin
      ptr_addr = w_ptr_pre_dec ? w_ptr_minus : w_ptr_val;
    end
  end

  // Per-byte arbitration: byte write beats word write beats pointer update;
  // an untargeted byte holds. The two bytes of a pair resolve independently.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_byte
      localparam logic [4:0] IDX  = 5'(gi);
      localparam logic [3:0] PAIR = 4'(gi / 2);
      localparam int         LSB  = (gi % 2) * WIDTH;

      logic w_byte_hit;
      logic w_word_hit;
      logic w_ptr_hit;

      assign w_byte_hit = wr_en      && (wr_addr == IDX);
      assign w_word_hit = wr_word_en && (wr_word_addr == PAIR);
      assign w_ptr_hit  = w_ptr_upd  && (w_ptr_pair == PAIR);

      assign w_next[gi] = w_byte_hit ? wr_data :
                          w_word_hit ? wr_word_data[LSB +: WIDTH] :
                          w_ptr_hit  ? w_ptr_new[LSB +: WIDTH] :
                                       r_regs[gi];
    end
  endgenerate

  // Register bank update; reset overrides every request in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else begin
        r_regs[i] <= w_next[i];
      end
    end
  end

  assign reg0_out  = r_regs[0];
  assign reg1_out  = r_regs[1];
  assign reg2_out  = r_regs[2];
  assign reg3_out  = r_regs[3];
  assign reg4_out  = r_regs[4];
  assign reg5_out  = r_regs[5];
  assign reg6_out  = r_regs[6];
  assign reg7_out  = r_regs[7];
  assign reg8_out  = r_regs[8];
  assign reg9_out  = r_regs[9];
  assign reg10_out = r_regs[10];
  assign reg11_out = r_regs[11];
  assign reg12_out = r_regs[12];
  assign reg13_out = r_regs[13];
  assign reg14_out = r_regs[14];
  assign reg15_out = r_regs[15];
  assign reg16_out = r_regs[16];
  assign reg17_out = r_regs[17];
  assign reg18_out = r_regs[18];
  assign reg19_out = r_regs[19];
  assign reg20_out = r_regs[20];
  assign reg21_out = r_regs[21];
  assign reg22_out = r_regs[22];
  assign reg23_out = r_regs[23];
  assign reg24_out = r_regs[24];
  assign reg25_out = r_regs[25];
  assign reg26_out = r_regs[26];
  assign reg27_out = r_regs[27];
  assign reg28_out = r_regs[28];
  assign reg29_out = r_regs[29];
  assign reg30_out = r_regs[30];
  assign reg31_out = r_regs[31];

endmodule

// File: tb/tb_register_bank_32x8.sv
// tb_register_bank_32x8
// Directed scenarios followed by random traffic, checked against an array
// model of the 32 registers that applies requests in priority order.

module tb_register_bank_32x8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_word_en;
  logic [3:0]  wr_word_addr;
  logic [15:0] wr_word_data;
  logic [1:0]  ptr_sel;
  logic        ptr_inc;
  logic        ptr_dec;
  logic [15:0] ptr_addr;
  logic [7:0]  dut_q [32];

  logic [7:0]  model [32];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_txn    = 0;

  always #5 clk = ~clk;

  register_bank_32x8 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_word_en(wr_word_en), .wr_word_addr(wr_word_addr), .wr_word_data(wr_word_data),
    .ptr_sel(ptr_sel), .ptr_inc(ptr_inc), .ptr_dec(ptr_dec), .ptr_addr(ptr_addr),
    .reg0_out(dut_q[0]),   .reg1_out(dut_q[1]),   .reg2_out(dut_q[2]),   .reg3_out(dut_q[3]),
    .reg4_out(dut_q[4]),   .reg5_out(dut_q[5]),   .reg6_out(dut_q[6]),   .reg7_out(dut_q[7]),
    .reg8_out(dut_q[8]),   .reg9_out(dut_q[9]),   .reg10_out(dut_q[10]), .reg11_out(dut_q[11]),
    .reg12_out(dut_q[12]), .reg13_out(dut_q[13]), .reg14_out(dut_q[14]), .reg15_out(dut_q[15]),
    .reg16_out(dut_q[16]), .reg17_out(dut_q[17]), .reg18_out(dut_q[18]), .reg19_out(dut_q[19]),
    .reg20_out(dut_q[20]), .reg21_out(dut_q[21]), .reg22_out(dut_q[22]), .reg23_out(dut_q[23]),
    .reg24_out(dut_q[24]), .reg25_out(dut_q[25]), .reg26_out(dut_q[26]), .reg27_out(dut_q[27]),
    .reg28_out(dut_q[28]), .reg29_out(dut_q[29]), .reg30_out(dut_q[30]), .reg31_out(dut_q[31])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Current value of pointer pair X(1)/Y(2)/Z(3) in the model.
  function automatic logic [15:0] model_ptr(input logic [1:0] sel);
    int lo;
    lo = 24 + 2 * int'(sel);
    return {model[lo + 1], model[lo]};
  endfunction

  // One clock: drive after the falling edge, check ptr_addr mid-cycle,
  // then check every register just after the rising edge.
  task automatic cycle(input string tag, input logic rst,
                       input logic we, input logic [4:0] wa, input logic [7:0] wd,
                       input logic wwe, input logic [3:0] wwa, input logic [15:0] wwd,
                       input logic [1:0] sel, input logic inc, input logic dec);
    logic [15:0] p;
    logic [15:0] exp_addr;
    logic [15:0] np;
    int          lo;
    @(negedge clk);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    wr_word_en = wwe; wr_word_addr = wwa; wr_word_data = wwd;
    ptr_sel = sel; ptr_inc = inc; ptr_dec = dec;
    #1;
    if (sel == 2'd0) begin
      exp_addr = 16'h0000;
    end else begin
      p = model_ptr(sel);
      exp_addr = (dec && !inc) ? p - 16'd1 : p;
    end
    check({tag, " ptr_addr"}, ptr_addr, exp_addr);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 8'h00;
    end else begin
      // Lowest priority first so higher-priority writers overwrite it.
      if (sel != 2'd0 && inc != dec) begin
        lo = 24 + 2 * int'(sel);
        np = inc ? model_ptr(sel) + 16'd1 : model_ptr(sel) - 16'd1;
        model[lo]     = np[7:0];
        model[lo + 1] = np[15:8];
      end
      if (wwe) begin
        model[2 * int'(wwa)]     = wwd[7:0];
        model[2 * int'(wwa) + 1] = wwd[15:8];
      end
      if (we) model[wa] = wd;
    end
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s r%0d", tag, i), {8'h00, dut_q[i]}, {8'h00, model[i]});
    end
    n_txn++;
    $display("txn %0d %-12s rst=%0d we=%0d a=%0d d=%h wwe=%0d wa=%0d wd=%h sel=%0d inc=%0d dec=%0d addr=%h",
             n_txn, tag, rst, we, wa, wd, wwe, wwa, wwd, sel, inc, dec, ptr_addr);
  endtask

  initial begin
    logic [15:0] rwd;
    logic        rrst;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_word_en = 1'b0; wr_word_addr = '0; wr_word_data = '0;
    ptr_sel = '0; ptr_inc = 1'b0; ptr_dec = 1'b0;

    // Reset, then reset again with a byte write that must be ignored.
    cycle("reset0",   1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0);
    cycle("wr_r3",    0, 1, 3, 8'hA5, 0, 0, 16'h0000, 0, 0, 0);
    cycle("wr_r31",   0, 1, 31, 8'h3C, 0, 0, 16'h0000, 0, 0, 0);
    cycle("reset_we", 1, 1, 5, 8'hFF, 0, 0, 16'h0000, 1, 1, 0);
    check("reset ptr_addr idle", ptr_addr, 16'h0000);

    // Byte and word write latency.
    cycle("byte_r17",  0, 1, 17, 8'h5A, 0, 0, 16'h0000, 0, 0, 0);
    cycle("word_p12",  0, 0, 0, 8'h00, 1, 12, 16'hBEEF, 0, 0, 0);

    // X increment wrap 0xFFFF -> 0x0000.
    cycle("set_x",     0, 0, 0, 8'h00, 1, 13, 16'hFFFF, 0, 0, 0);
    cycle("x_inc_wrap",0, 0, 0, 8'h00, 0, 0, 16'h0000, 1, 1, 0);

    // Z pre-decrement with borrow 0x0100 -> 0x00FF.
    cycle("set_z",     0, 0, 0, 8'h00, 1, 15, 16'h0100, 0, 0, 0);
    cycle("z_dec",     0, 0, 0, 8'h00, 0, 0, 16'h0000, 3, 0, 1);
    // 0x0000 - 1 wraps to 0xFFFF.
    cycle("set_z0",    0, 0, 0, 8'h00, 1, 15, 16'h0000, 0, 0, 0);
    cycle("z_dec_wrap",0, 0, 0, 8'h00, 0, 0, 16'h0000, 3, 0, 1);

    // Collision: byte write, word write and Y increment all hit Y.
    cycle("set_y",     0, 0, 0, 8'h00, 1, 14, 16'h10FF, 0, 0, 0);
    cycle("collide",   0, 1, 28, 8'h77, 1, 14, 16'h1234, 2, 1, 0);
    check("collide r28", {8'h00, dut_q[28]}, 16'h0077);
    check("collide r29", {8'h00, dut_q[29]}, 16'h0012);
    // Byte write to R26 with X increment: low from byte, high from P+1.
    cycle("set_x2",    0, 0, 0, 8'h00, 1, 13, 16'h12FF, 0, 0, 0);
    cycle("x_split",   0, 1, 26, 8'h42, 0, 0, 16'h0000, 1, 1, 0);
    check("x_split r27", {8'h00, dut_q[27]}, 16'h0013);
    // Both inc and dec: no update, plain access.
    cycle("y_both",    0, 0, 0, 8'h00, 0, 0, 16'h0000, 2, 1, 1);
    // sel=0 with inc: no update, address 0.
    cycle("sel0_inc",  0, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 0);
    // Reset in the middle of a pointer sequence.
    cycle("y_inc",     0, 0, 0, 8'h00, 0, 0, 16'h0000, 2, 1, 0);
    cycle("reset_mid", 1, 1, 29, 8'h99, 1, 14, 16'hAAAA, 2, 1, 0);

    // Random traffic, biased toward the pointer pairs and wrap values.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0:       rwd = 16'hFFFF;
        1:       rwd = 16'h0000;
        default: rwd = 16'($urandom);
      endcase
      rrst = ($urandom_range(0, 49) == 0);
      cycle("rand", rrst,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) != 0) ? 5'($urandom_range(24, 31)) : 5'($urandom),
            8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) != 0) ? 4'($urandom_range(12, 15)) : 4'($urandom),
            rwd,
            2'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
